// File: rtl/sync_event_detector.sv
// rtl/sync_event_detector.sv - glitch filter, edge pulses, valid/ready event and saturating count for a synchronized level
module sync_event_detector #(
    parameter int FILTER_LEN  = 4,
    parameter int EDGE_SEL    = 2,
    parameter int CNT_W       = 8,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic             clk_b,
    input  logic             rst,
    input  logic             signal_b,
    output logic             filt_level,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             evt_valid,
    output logic             evt_rising,
    input  logic             evt_ready,
    output logic             evt_overflow,
    output logic [CNT_W-1:0] evt_count,
    input  logic             cnt_clear
);

    localparam int             SW         = $clog2(FILTER_LEN) + 1;
    localparam logic [SW-1:0]  STAB_LAST  = SW'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SW-1:0]    stab_q, stab_d;
    logic             filt_q, filt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             valid_q, valid_d;
    logic             rising_q, rising_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic differ;
    logic accept;
    logic qual;
    logic take;
    logic drop;

    // Filter: count consecutive differing samples, accept the new level on the last one
    always_comb begin
        differ = (signal_b != filt_q);
        accept = differ && (stab_q == STAB_LAST);
        stab_d = '0;
        if (differ && !accept) begin
            stab_d = stab_q + SW'(1);
        end
        filt_d = accept ? signal_b : filt_q;
        rise_d = accept && signal_b;
        fall_d = accept && !signal_b;
    end

    // Event handshake, overflow flag and saturating counter driven by qualifying edges
    always_comb begin
        if (EDGE_SEL == 0) begin
            qual = rise_d;
        end else if (EDGE_SEL == 1) begin
            qual = fall_d;
        end else begin
            qual = accept;
        end
        take = qual && (!valid_q || evt_ready);
        drop = qual && valid_q && !evt_ready;

        valid_d  = valid_q;
        rising_d = rising_q;
        if (take) begin
            valid_d  = 1'b1;
            rising_d = signal_b;
        end else if (valid_q && evt_ready) begin
            valid_d = 1'b0;
        end

        // A drop in the same cycle as a clear still leaves the flag set
        ovf_d = drop || (ovf_q && !cnt_clear);

        cnt_d = cnt_q;
        if (cnt_clear) begin
            cnt_d = qual ? CNT_W'(1) : '0;
        end else if (qual && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            stab_q   <= '0;
            filt_q   <= RESET_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            valid_q  <= 1'b0;
            rising_q <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stab_q   <= stab_d;
            filt_q   <= filt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            valid_q  <= valid_d;
            rising_q <= rising_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign filt_level   = filt_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign evt_valid    = valid_q;
    assign evt_rising   = rising_q;
    assign evt_overflow = ovf_q;
    assign evt_count    = cnt_q;

endmodule

// File: tb/tb_sync_event_detector.sv
// tb/tb_sync_event_detector.sv - scoreboard bench for sync_event_detector
module tb_sync_event_detector;

    typedef struct {
        bit rise;
        int cyc;
    } pulse_t;

    logic clk_b = 1'b0;
    always #5 clk_b = ~clk_b;

    int cyc = 0;
    always @(posedge clk_b) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Instance A: default parameters
    logic       rst_a = 1'b1, sig_a = 1'b0, rdy_a = 1'b0, clr_a = 1'b0;
    logic       filt_a, rise_a, fall_a, val_a, evr_a, ovf_a;
    logic [7:0] cnt_a;

    sync_event_detector u_a (
        .clk_b(clk_b), .rst(rst_a), .signal_b(sig_a), .filt_level(filt_a),
        .rise_pulse(rise_a), .fall_pulse(fall_a), .evt_valid(val_a),
        .evt_rising(evr_a), .evt_ready(rdy_a), .evt_overflow(ovf_a),
        .evt_count(cnt_a), .cnt_clear(clr_a)
    );

    // Instance B: rising-only, 2-bit counter
    logic       rst_b = 1'b1, sig_b = 1'b0, rdy_b = 1'b1, clr_b = 1'b0;
    logic       filt_b, rise_b, fall_b, val_b, evr_b, ovf_b;
    logic [1:0] cnt_b;

    sync_event_detector #(.FILTER_LEN(4), .EDGE_SEL(0), .CNT_W(2), .RESET_LEVEL(1'b0)) u_b (
        .clk_b(clk_b), .rst(rst_b), .signal_b(sig_b), .filt_level(filt_b),
        .rise_pulse(rise_b), .fall_pulse(fall_b), .evt_valid(val_b),
        .evt_rising(evr_b), .evt_ready(rdy_b), .evt_overflow(ovf_b),
        .evt_count(cnt_b), .cnt_clear(clr_b)
    );

    pulse_t pq_a[$];
    pulse_t pq_b[$];
    bit     tq_a[$];
    bit     tq_b[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_b);
            #1;
        end
    endtask

    task automatic push_a(input bit rise);
        pulse_t p;
        p.rise = rise;
        p.cyc  = cyc + 4;
        pq_a.push_back(p);
    endtask

    task automatic push_b(input bit rise);
        pulse_t p;
        p.rise = rise;
        p.cyc  = cyc + 4;
        pq_b.push_back(p);
    endtask

    // Pulse monitor A
    always @(negedge clk_b) begin
        if (!rst_a && (rise_a || fall_a)) begin
            pulse_t p;
            if (pq_a.size() == 0) begin
                chk("a_unexpected_pulse", {rise_a, fall_a}, 0);
            end else begin
                p = pq_a.pop_front();
                chk("a_pulse_type", {rise_a, fall_a}, p.rise ? 2 : 1);
                chk("a_pulse_cycle", cyc, p.cyc);
            end
        end
    end

    // Transfer monitor A
    always @(negedge clk_b) begin
        if (!rst_a && val_a && rdy_a) begin
            bit e;
            if (tq_a.size() == 0) begin
                chk("a_unexpected_transfer", 1, 0);
            end else begin
                e = tq_a.pop_front();
                chk("a_transfer_rising", evr_a, e);
            end
        end
    end

    // Pulse monitor B
    always @(negedge clk_b) begin
        if (!rst_b && (rise_b || fall_b)) begin
            pulse_t p;
            if (pq_b.size() == 0) begin
                chk("b_unexpected_pulse", {rise_b, fall_b}, 0);
            end else begin
                p = pq_b.pop_front();
                chk("b_pulse_type", {rise_b, fall_b}, p.rise ? 2 : 1);
                chk("b_pulse_cycle", cyc, p.cyc);
            end
        end
    end

    // Transfer monitor B
    always @(negedge clk_b) begin
        if (!rst_b && val_b && rdy_b) begin
            bit e;
            if (tq_b.size() == 0) begin
                chk("b_unexpected_transfer", 1, 0);
            end else begin
                e = tq_b.pop_front();
                chk("b_transfer_rising", evr_b, e);
            end
        end
    end

    initial begin
        step(3);
        chk("reset_filt", filt_a, 0);
        chk("reset_pulses", {rise_a, fall_a}, 0);
        chk("reset_valid", val_a, 0);
        chk("reset_count", cnt_a, 0);
        chk("reset_ovf", ovf_a, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        step(2);

        // 1: accepted rising edge
        sig_a = 1'b1; push_a(1'b1);
        step(10);
        chk("t1_filt", filt_a, 1);
        chk("t1_valid", val_a, 1);
        chk("t1_rising", evr_a, 1);
        chk("t1_count", cnt_a, 1);
        rdy_a = 1'b1; tq_a.push_back(1'b1);
        step(1);
        rdy_a = 1'b0;
        chk("t1_valid_after_xfer", val_a, 0);

        // back to low, then 3-cycle glitch
        sig_a = 1'b0; push_a(1'b0);
        step(6);
        chk("t2_fall_count", cnt_a, 2);
        rdy_a = 1'b1; tq_a.push_back(1'b0);
        step(1);
        rdy_a = 1'b0;
        clr_a = 1'b1;
        step(1);
        clr_a = 1'b0;
        chk("t2_cleared", cnt_a, 0);
        sig_a = 1'b1;
        step(3);
        sig_a = 1'b0;
        step(6);
        chk("t2_filt", filt_a, 0);
        chk("t2_count", cnt_a, 0);
        chk("t2_valid", val_a, 0);

        // 3: stalled consumer, three edges
        sig_a = 1'b1; push_a(1'b1); step(6);
        sig_a = 1'b0; push_a(1'b0); step(6);
        sig_a = 1'b1; push_a(1'b1); step(6);
        chk("t3_valid", val_a, 1);
        chk("t3_rising", evr_a, 1);
        chk("t3_ovf", ovf_a, 1);
        chk("t3_count", cnt_a, 3);
        rdy_a = 1'b1; tq_a.push_back(1'b1);
        step(1);
        rdy_a = 1'b0;
        chk("t3_valid_after_xfer", val_a, 0);

        // 5: clear coincident with qualifying edge, then with a drop
        sig_a = 1'b0; push_a(1'b0);
        step(3);
        clr_a = 1'b1;
        step(1);
        clr_a = 1'b0;
        chk("t5_count_clear_edge", cnt_a, 1);
        chk("t5_ovf_cleared", ovf_a, 0);
        chk("t5_valid", val_a, 1);
        sig_a = 1'b1; push_a(1'b1);
        step(3);
        clr_a = 1'b1;
        step(1);
        clr_a = 1'b0;
        chk("t5_ovf_set_wins", ovf_a, 1);
        chk("t5_count_clear_drop", cnt_a, 1);
        chk("t5_rising_held", evr_a, 0);
        step(2);

        // 6: async reset mid-filter with event pending
        sig_a = 1'b0;
        step(2);
        #1 rst_a = 1'b1;
        #1;
        chk("t6_filt", filt_a, 0);
        chk("t6_valid", val_a, 0);
        chk("t6_count", cnt_a, 0);
        chk("t6_ovf", ovf_a, 0);
        chk("t6_pulses", {rise_a, fall_a}, 0);
        sig_a = 1'b1;
        step(2);
        rst_a = 1'b0; push_a(1'b1);
        step(6);
        chk("t6_filt_after", filt_a, 1);
        chk("t6_count_after", cnt_a, 1);
        chk("t6_valid_after", val_a, 1);

        // 4: rising-only instance with saturating 2-bit counter
        for (int i = 0; i < 5; i++) begin
            sig_b = 1'b1; push_b(1'b1); tq_b.push_back(1'b1);
            step(6);
            sig_b = 1'b0; push_b(1'b0);
            step(6);
        end
        chk("t4_count_sat", cnt_b, 3);
        chk("t4_valid", val_b, 0);
        chk("t4_ovf", ovf_b, 0);

        step(2);
        chk("pq_a_empty", pq_a.size(), 0);
        chk("tq_a_empty", tq_a.size(), 0);
        chk("pq_b_empty", pq_b.size(), 0);
        chk("tq_b_empty", tq_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
